char_scan_decoder: RTL and testbench

Receive-side counterpart of the 4-character column-scan display driver. Samples the scanned stream of column index plus 4-bit line pattern, reassembles each 4×4 glyph, reverse-maps it to its hex code, and delivers decoded characters and complete 4-character frames. Used for display loop-back self-test and for decoding a scanned display bus received from another tile.

---
 rtl/char_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_char_scan_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/char_scan_decoder.sv
// Receive side of the 4-character column-scan display: reassembles scanned
// 4x4 glyphs, reverse-maps them to hex codes and publishes complete frames.
module char_scan_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_valid,
  input  logic [3:0]  column,
  input  logic [3:0]  line,
  output logic        char_valid,
  output logic [3:0]  char_data,
  output logic [1:0]  char_index,
  output logic        char_error,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        sync_error,
  output logic        locked
);

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  expected_q;
  logic [15:0] glyph_q;
  logic [11:0] shadow_q;
  logic        bad_q;

  logic        char_valid_q;
  logic [3:0]  char_data_q;
  logic [1:0]  char_index_q;
  logic        char_error_q;
  logic [15:0] frame_q;
  logic        frame_valid_q;
  logic        sync_error_q;
  logic        locked_q;

  logic [1:0]  col_c;
  logic [1:0]  char_pos;
  logic [15:0] glyph_d;
  logic [3:0]  dec_code;
  logic        dec_err;

  assign col_c    = column[1:0];
  assign char_pos = column[3:2];

  // Column 0 starts a fresh glyph so stale pixels never leak into a new char.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    glyph_d = (col_c == 2'd0) ? 16'h0000 : glyph_q;
    glyph_d[4'd15 - {2'b00, col_c}] = line[3];
    glyph_d[4'd11 - {2'b00, col_c}] = line[2];
    glyph_d[4'd7  - {2'b00, col_c}] = line[1];
    glyph_d[4'd3  - {2'b00, col_c}] = line[0];
  end

  // Reverse glyph map on the glyph including the current column.
  always_comb begin
    dec_code = 4'h0;
    dec_err  = 1'b0;
    case (glyph_d)
      16'hF99F: dec_code = 4'h0;
      16'hF22F: dec_code = 4'h1;
      16'hF24F: dec_code = 4'h2;
      16'hF71F: dec_code = 4'h3;
      16'h99F1: dec_code = 4'h4;
      16'hF8F7: dec_code = 4'h5;
      16'h8F9F: dec_code = 4'h6;
      16'hF111: dec_code = 4'h7;
      16'hEBD7: dec_code = 4'h8;
      16'hF9F1: dec_code = 4'h9;
      16'hF9F9: dec_code = 4'hA;
      16'hCADA: dec_code = 4'hB;
      16'hF88F: dec_code = 4'hC;
      16'hE99E: dec_code = 4'hD;
      16'hFE8F: dec_code = 4'hE;
      16'hF8E8: dec_code = 4'hF;
      default:  dec_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of its neighbours.
    if (reset) begin
      state_q       <= HUNT;
      expected_q    <= 4'd0;
      glyph_q       <= 16'h0000;
      // NOTE: the shadow frame buffer is reset explicitly; a partial frame
      // from before reset must never surface in a later frame.
      shadow_q      <= 12'h000;
      bad_q         <= 1'b0;
      char_valid_q  <= 1'b0;
      char_data_q   <= 4'h0;
      char_index_q  <= 2'd0;
      char_error_q  <= 1'b0;
      frame_q       <= 16'h0000;
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      char_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;

      if (scan_valid) begin
        case (state_q)
          HUNT: begin
            if (column == 4'd0) begin
              glyph_q    <= glyph_d;
              expected_q <= 4'd1;
              bad_q      <= 1'b0;
              state_q    <= CAPTURE;
              locked_q   <= 1'b1;
            end
          end

          CAPTURE: begin
            if (column == expected_q) begin
              glyph_q    <= glyph_d;
              expected_q <= expected_q + 4'd1;
              if (column == 4'd0) bad_q <= 1'b0;

              if (col_c == 2'd3) begin
                char_valid_q <= 1'b1;
                char_data_q  <= dec_code;
                char_index_q <= char_pos;
                char_error_q <= dec_err;
                if (dec_err) bad_q <= 1'b1;

                case (char_pos)
                  2'd0:    shadow_q[3:0]  <= dec_code;
                  2'd1:    shadow_q[7:4]  <= dec_code;
                  2'd2:    shadow_q[11:8] <= dec_code;
                  default: begin
                    // Char 3 completes the frame; publish only if all four were clean.
                    if (!bad_q && !dec_err) begin
                      frame_q       <= {dec_code, shadow_q};
                      frame_valid_q <= 1'b1;
                    end
                  end
                endcase
              end
            end else begin
              sync_error_q <= 1'b1;
              if (column == 4'd0) begin
                glyph_q    <= glyph_d;
                expected_q <= 4'd1;
                bad_q      <= 1'b0;
              end else begin
                glyph_q    <= 16'h0000;
                expected_q <= 4'd0;
                state_q    <= HUNT;
                locked_q   <= 1'b0;
              end
            end
          end

          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign char_valid  = char_valid_q;
  assign char_data   = char_data_q;
  assign char_index  = char_index_q;
  assign char_error  = char_error_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign sync_error  = sync_error_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_char_scan_decoder.sv
// Directed bench for char_scan_decoder: scans glyphs column by column and
// checks decoded chars, frames, sync errors and lock state.
module tb_char_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_valid;
  logic [3:0]  column;
  logic [3:0]  line;
  logic        char_valid;
  logic [3:0]  char_data;
  logic [1:0]  char_index;
  logic        char_error;
  logic [15:0] frame;
  logic        frame_valid;
  logic        sync_error;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;

  char_scan_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .column     (column),
    .line       (line),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_index (char_index),
    .char_error (char_error),
    .frame      (frame),
    .frame_valid(frame_valid),
    .sync_error (sync_error),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Display font used to generate the scanned stimulus.
  function automatic logic [15:0] glyph_of(input logic [3:0] code);
    case (code)
      4'h0: return 16'hF99F;  4'h1: return 16'hF22F;
      4'h2: return 16'hF24F;  4'h3: return 16'hF71F;
      4'h4: return 16'h99F1;  4'h5: return 16'hF8F7;
      4'h6: return 16'h8F9F;  4'h7: return 16'hF111;
      4'h8: return 16'hEBD7;  4'h9: return 16'hF9F1;
      4'hA: return 16'hF9F9;  4'hB: return 16'hCADA;
      4'hC: return 16'hF88F;  4'hD: return 16'hE99E;
      4'hE: return 16'hFE8F;  default: return 16'hF8E8;
    endcase
  endfunction

  function automatic logic [3:0] col_line(input logic [15:0] g, input int c);
    return {g[15-c], g[11-c], g[7-c], g[3-c]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge sample them, settle 1 time unit.
  task automatic step(input logic v, input logic [3:0] col, input logic [3:0] ln);
    scan_valid = v;
    column     = col;
    line       = ln;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {char_valid, char_data, char_index, char_error,
                           frame_valid, sync_error, locked}, 32'd0);
    check({tag, "_frame"}, {16'h0, frame}, 32'd0);
  endtask

  // Scans columns c_from..3 of one char, optionally idling gap cycles after
  // each non-final column, then checks the decoded result.
  task automatic scan_char(input logic [1:0] pos, input logic [15:0] g, input int c_from,
                           input int gap, input logic [3:0] exp_code,
                           input logic exp_err, input logic exp_fv);
    for (int c = c_from; c < 4; c++) begin
      step(1'b1, {pos, 2'(c)}, col_line(g, c));
      if (c < 3) begin
        check("mid_char_quiet", {30'd0, char_valid, sync_error}, 32'd0);
        for (int k = 0; k < gap; k++) begin
          step(1'b0, 4'd0, 4'd0);
          check("gap_quiet", {30'd0, char_valid, sync_error}, 32'd0);
        end
      end
    end
    check("char_valid", {31'd0, char_valid}, 32'd1);
    check("char_index", {30'd0, char_index}, {30'd0, pos});
    check("char_data",  {28'd0, char_data},  {28'd0, exp_code});
    check("char_error", {31'd0, char_error}, {31'd0, exp_err});
    check("frame_valid_at_char", {31'd0, frame_valid}, {31'd0, exp_fv});
    check("no_sync_error", {31'd0, sync_error}, 32'd0);
    check("locked_in_capture", {31'd0, locked}, 32'd1);
  endtask

  // codes = {char3, char2, char1, char0}; all glyphs clean.
  task automatic scan_frame(input logic [15:0] codes, input int gap);
    for (int p = 0; p < 4; p++)
      scan_char(2'(p), glyph_of(codes[p*4 +: 4]), 0, gap, codes[p*4 +: 4], 1'b0, p == 3);
  endtask

  initial begin
    reset      = 1'b1;
    scan_valid = 1'b0;
    column     = 4'd0;
    line       = 4'd0;
    step(1'b0, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    check_all_zero("reset_state");

    // Back-to-back frame 1,A,7,F; locked from the cycle after column 0.
    step(1'b1, 4'd0, col_line(glyph_of(4'h1), 0));
    check("locked_after_col0", {31'd0, locked}, 32'd1);
    scan_char(2'd0, glyph_of(4'h1), 1, 0, 4'h1, 1'b0, 1'b0);
    scan_char(2'd1, glyph_of(4'hA), 0, 0, 4'hA, 1'b0, 1'b0);
    scan_char(2'd2, glyph_of(4'h7), 0, 0, 4'h7, 1'b0, 1'b0);
    scan_char(2'd3, glyph_of(4'hF), 0, 0, 4'hF, 1'b0, 1'b1);
    check("frame_F7A1", {16'h0, frame}, 32'h0000_F7A1);

    // Continuous second frame without relock, then one with 3-cycle gaps.
    scan_frame(16'h5E03, 0);
    check("frame_5E03", {16'h0, frame}, 32'h0000_5E03);
    scan_frame(16'hB2C9, 3);
    check("frame_B2C9_gaps", {16'h0, frame}, 32'h0000_B2C9);

    // Char 2 corrupted: error reported, frame held, then next clean frame lands.
    scan_char(2'd0, glyph_of(4'h4), 0, 0, 4'h4, 1'b0, 1'b0);
    scan_char(2'd1, glyph_of(4'h5), 0, 0, 4'h5, 1'b0, 1'b0);
    scan_char(2'd2, 16'h0000,       0, 0, 4'h0, 1'b1, 1'b0);
    scan_char(2'd3, glyph_of(4'h6), 0, 0, 4'h6, 1'b0, 1'b0);
    check("frame_held_bad", {16'h0, frame}, 32'h0000_B2C9);
    scan_frame(16'h018D, 0);
    check("frame_018D", {16'h0, frame}, 32'h0000_018D);

    // Reset, then a stream starting at column 6 is ignored until column 0.
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    check_all_zero("reset_again");
    for (int c = 6; c < 16; c++) begin
      step(1'b1, 4'(c), col_line(glyph_of(4'h3), c % 4));
      check("hunt_quiet", {29'd0, char_valid, sync_error, locked}, 32'd0);
    end
    scan_frame(16'h5432, 0);
    check("frame_5432", {16'h0, frame}, 32'h0000_5432);

    // Column 5 followed by 9: sync error, unlock, no char 1, relock on column 0.
    scan_char(2'd0, glyph_of(4'h7), 0, 0, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'd4, col_line(glyph_of(4'hB), 0));
    step(1'b1, 4'd5, col_line(glyph_of(4'hB), 1));
    step(1'b1, 4'd9, col_line(glyph_of(4'hB), 1));
    check("sync_5_9", {29'd0, char_valid, sync_error, locked}, 32'b010);
    step(1'b0, 4'd0, 4'd0);
    check("sync_pulse_ends", {31'd0, sync_error}, 32'd0);
    step(1'b1, 4'd10, col_line(glyph_of(4'hB), 2));
    step(1'b1, 4'd11, col_line(glyph_of(4'hB), 3));
    check("hunt_after_sync", {29'd0, char_valid, sync_error, locked}, 32'd0);
    scan_frame(16'hDCBA, 0);
    check("frame_DCBA", {16'h0, frame}, 32'h0000_DCBA);

    // Offending sample at column[1:0]==3 yields no char.
    scan_char(2'd0, glyph_of(4'hE), 0, 0, 4'hE, 1'b0, 1'b0);
    step(1'b1, 4'd4, col_line(glyph_of(4'h0), 0));
    step(1'b1, 4'd7, col_line(glyph_of(4'h0), 3));
    check("sync_col7", {29'd0, char_valid, sync_error, locked}, 32'b010);

    // Column 5 followed by 0: sync error, stay locked, decode resumes.
    scan_char(2'd0, glyph_of(4'h1), 0, 0, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'd4, col_line(glyph_of(4'h9), 0));
    step(1'b1, 4'd5, col_line(glyph_of(4'h9), 1));
    step(1'b1, 4'd0, col_line(glyph_of(4'h8), 0));
    check("sync_5_0", {29'd0, char_valid, sync_error, locked}, 32'b011);
    scan_char(2'd0, glyph_of(4'h8), 1, 0, 4'h8, 1'b0, 1'b0);
    scan_char(2'd1, glyph_of(4'h2), 0, 0, 4'h2, 1'b0, 1'b0);
    scan_char(2'd2, glyph_of(4'h3), 0, 0, 4'h3, 1'b0, 1'b0);
    scan_char(2'd3, glyph_of(4'h4), 0, 0, 4'h4, 1'b0, 1'b1);
    check("frame_4328", {16'h0, frame}, 32'h0000_4328);

    // Reset after column 10; the tail of that frame is ignored.
    scan_char(2'd0, glyph_of(4'h1), 0, 0, 4'h1, 1'b0, 1'b0);
    scan_char(2'd1, glyph_of(4'h2), 0, 0, 4'h2, 1'b0, 1'b0);
    for (int c = 8; c < 11; c++) step(1'b1, 4'(c), col_line(glyph_of(4'h3), c - 8));
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    check_all_zero("reset_mid_frame");
    for (int c = 11; c < 16; c++) begin
      step(1'b1, 4'(c), col_line(glyph_of(4'h3), c % 4));
      check("tail_ignored", {28'd0, char_valid, frame_valid, sync_error, locked}, 32'd0);
    end
    scan_frame(16'hC896, 0);
    check("frame_C896", {16'h0, frame}, 32'h0000_C896);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
